// File: rtl/spram_arbiter.sv
// spram_arbiter: round-robin share of one 16K x 16 SPRAM between two byte-wide ports,
// with optional zero-fill sweep after reset and one-cycle read latency.
module spram_arbiter #(
   parameter bit CLEAR_ON_RESET = 1'b1,
   parameter int CLEAR_WORDS    = 16384
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        p0_valid_i,
   output logic        p0_ready_o,
   input  logic        p0_we_i,
   input  logic [14:0] p0_addr_i,
   input  logic [7:0]  p0_wdata_i,
   output logic        p0_rvalid_o,
   output logic [7:0]  p0_rdata_o,
   input  logic        p1_valid_i,
   output logic        p1_ready_o,
   input  logic        p1_we_i,
   input  logic [14:0] p1_addr_i,
   input  logic [7:0]  p1_wdata_i,
   output logic        p1_rvalid_o,
   output logic [7:0]  p1_rdata_o,
   output logic [3:0]  mem_we_o,
   output logic [13:0] mem_addr_o,
   output logic [15:0] mem_din_o,
   input  logic [15:0] mem_dout_i,
   output logic        init_done_o
);
   typedef enum logic {CLEAR, RUN} state_t;
   localparam logic [13:0] LAST = 14'(CLEAR_WORDS - 1);
   state_t      state_q, state_d;
   logic [13:0] cnt_q, cnt_d;
   logic        ptr_q, ptr_d, init_q, init_d;
   logic        rv0_q, rv1_q, sel_q;
   logic [7:0]  hold0_q, hold1_q, rbyte;
   logic        clr, run, g0, g1, act, we_s;
   logic [14:0] addr_s;
   logic [7:0]  wd_s;
   // Gating with rst_n keeps the SPRAM write-disabled while reset is held.
   assign clr    = rst_n && state_q == CLEAR;
   assign run    = rst_n && state_q == RUN;
   assign g0     = run && p0_valid_i && (!p1_valid_i || !ptr_q);
   assign g1     = run && p1_valid_i && (!p0_valid_i || ptr_q);
   assign act    = g0 || g1;
   assign addr_s = g1 ? p1_addr_i : p0_addr_i;
   assign we_s   = g1 ? p1_we_i : p0_we_i;
   assign wd_s   = g1 ? p1_wdata_i : p0_wdata_i;
   assign rbyte  = sel_q ? mem_dout_i[15:8] : mem_dout_i[7:0];
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      ptr_d       = g0 ? 1'b1 : g1 ? 1'b0 : ptr_q;
      mem_we_o    = clr ? 4'hF : (act && we_s) ? (addr_s[0] ? 4'hC : 4'h3) : 4'h0;
      mem_addr_o  = clr ? cnt_q : act ? addr_s[14:1] : 14'd0;
      mem_din_o   = (act && we_s) ? {wd_s, wd_s} : 16'd0;
      p0_ready_o  = g0;
      p1_ready_o  = g1;
      p0_rvalid_o = rv0_q;
      p1_rvalid_o = rv1_q;
      p0_rdata_o  = rv0_q ? rbyte : hold0_q;
      p1_rdata_o  = rv1_q ? rbyte : hold1_q;
      init_done_o = init_q;
      if (clr) begin
         cnt_d = cnt_q + 14'd1;
         if (cnt_q == LAST) state_d = RUN;
      end
      init_d = state_d == RUN;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= CLEAR_ON_RESET ? CLEAR : RUN;
         cnt_q   <= '0;
         ptr_q   <= 1'b0;
         init_q  <= 1'b0;
         rv0_q   <= 1'b0;
         rv1_q   <= 1'b0;
         sel_q   <= 1'b0;
         hold0_q <= '0;
         hold1_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
         init_q  <= init_d;
         rv0_q   <= g0 && !p0_we_i;
         rv1_q   <= g1 && !p1_we_i;
         if (act && !we_s) sel_q <= addr_s[0];
         hold0_q <= p0_rdata_o;
         hold1_q <= p1_rdata_o;
      end
   end
endmodule

// File: tb/tb_spram_arbiter.sv
// tb_spram_arbiter: directed checks of clear sweep, byte access, round-robin and reset abort
// against a behavioural nibble-masked SPRAM model.
module tb_spram_arbiter;
   logic        clk = 1'b0;
   logic        rst_n, preload;
   logic        p0_valid, p0_ready, p0_we, p0_rvalid;
   logic [14:0] p0_addr;
   logic [7:0]  p0_wdata, p0_rdata;
   logic        p1_valid, p1_ready, p1_we, p1_rvalid;
   logic [14:0] p1_addr;
   logic [7:0]  p1_wdata, p1_rdata;
   logic [3:0]  mem_we;
   logic [13:0] mem_addr;
   logic [15:0] mem_din, mem_dout, m;
   logic        init_done;
   logic [15:0] mdl [0:16383];
   int          checks = 0, errors = 0;

   always #5 clk = ~clk;

   spram_arbiter #(.CLEAR_ON_RESET(1'b1), .CLEAR_WORDS(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .p0_valid_i(p0_valid), .p0_ready_o(p0_ready), .p0_we_i(p0_we), .p0_addr_i(p0_addr),
      .p0_wdata_i(p0_wdata), .p0_rvalid_o(p0_rvalid), .p0_rdata_o(p0_rdata),
      .p1_valid_i(p1_valid), .p1_ready_o(p1_ready), .p1_we_i(p1_we), .p1_addr_i(p1_addr),
      .p1_wdata_i(p1_wdata), .p1_rvalid_o(p1_rvalid), .p1_rdata_o(p1_rdata),
      .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_din_o(mem_din), .mem_dout_i(mem_dout),
      .init_done_o(init_done)
   );

   assign m = {{4{mem_we[3]}}, {4{mem_we[2]}}, {4{mem_we[1]}}, {4{mem_we[0]}}};
   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 16; i++) mdl[i] <= 16'hDEAD;
         mdl[16'h80] <= 16'h0000;
      end else if (|mem_we) mdl[mem_addr] <= (mdl[mem_addr] & ~m) | (mem_din & m);
      mem_dout <= mdl[mem_addr];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n = 1'b0; preload = 1'b1;
      p0_valid = 1'b1; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
      p1_valid = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;
      repeat (2) @(negedge clk);
      #1 chk("rst_p0_ready", p0_ready, 0); chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0); chk("rst_mem_din", mem_din, 0);
      chk("rst_init", init_done, 0); chk("rst_p0_rvalid", p0_rvalid, 0);
      chk("rst_p0_rdata", p0_rdata, 0); chk("rst_p1_rdata", p1_rdata, 0);
      preload = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      // clear sweep of 16 words, p0 held valid throughout
      for (int i = 0; i < 16; i++) begin
         #1 chk("clr_we", mem_we, 4'hF); chk("clr_addr", mem_addr, i);
         chk("clr_din", mem_din, 0); chk("clr_ready", p0_ready, 0); chk("clr_init", init_done, 0);
         @(negedge clk);
      end
      #1 chk("clr_done", init_done, 1); chk("run_p0_ready", p0_ready, 1);
      chk("clr_mem0", mdl[0], 0); chk("clr_mem15", mdl[15], 0);
      p0_valid = 1'b0;
      @(negedge clk);
      // byte write then reads
      p0_valid = 1'b1; p0_we = 1'b1; p0_addr = 15'h0003; p0_wdata = 8'hA5;
      #1 chk("wr_ready", p0_ready, 1); chk("wr_addr", mem_addr, 1);
      chk("wr_we", mem_we, 4'hC); chk("wr_din", mem_din, 16'hA5A5);
      @(negedge clk);
      p0_we = 1'b0; p0_addr = 15'h0002;
      #1 chk("rd_we", mem_we, 0); chk("rd_addr", mem_addr, 1); chk("rd_ready", p0_ready, 1);
      chk("wr_mem1", mdl[1], 16'hA500);
      @(negedge clk);
      p0_addr = 15'h0003;
      #1 chk("rd2_rvalid", p0_rvalid, 1); chk("rd2_rdata", p0_rdata, 8'h00);
      chk("rd2_p1_rvalid", p1_rvalid, 0);
      @(negedge clk);
      p0_valid = 1'b0;
      #1 chk("rd3_rvalid", p0_rvalid, 1); chk("rd3_rdata", p0_rdata, 8'hA5);
      @(negedge clk);
      #1 chk("idle_rvalid", p0_rvalid, 0); chk("idle_hold", p0_rdata, 8'hA5);
      chk("idle_we", mem_we, 0);
      @(negedge clk);
      // single requester p1, pointer currently at p1
      p1_valid = 1'b1; p1_we = 1'b1; p1_addr = 15'h0002; p1_wdata = 8'h5A;
      #1 chk("s_ready0", p1_ready, 1); chk("s_p0_ready", p0_ready, 0);
      chk("s_we", mem_we, 4'h3); chk("s_din", mem_din, 16'h5A5A);
      @(negedge clk);
      p1_we = 1'b0;
      #1 chk("s_ready1", p1_ready, 1);
      @(negedge clk);
      p1_addr = 15'h0003;
      #1 chk("s_ready2", p1_ready, 1); chk("s_rvalid", p1_rvalid, 1);
      chk("s_raw", p1_rdata, 8'h5A); chk("s_p0_rvalid", p0_rvalid, 0);
      @(negedge clk);
      p1_valid = 1'b0;
      #1 chk("s_rvalid2", p1_rvalid, 1); chk("s_rdata2", p1_rdata, 8'hA5);
      @(negedge clk);
      // contention: both read, pointer back at p0
      p0_valid = 1'b1; p0_we = 1'b0; p0_addr = 15'h0003;
      p1_valid = 1'b1; p1_we = 1'b0; p1_addr = 15'h0002;
      #1 chk("c1_p0", p0_ready, 1); chk("c1_p1", p1_ready, 0);
      @(negedge clk);
      #1 chk("c2_p1", p1_ready, 1); chk("c2_p0", p0_ready, 0);
      chk("c2_rv0", p0_rvalid, 1); chk("c2_rd0", p0_rdata, 8'hA5); chk("c2_rv1", p1_rvalid, 0);
      @(negedge clk);
      #1 chk("c3_p0", p0_ready, 1); chk("c3_p1", p1_ready, 0);
      chk("c3_rv1", p1_rvalid, 1); chk("c3_rd1", p1_rdata, 8'h5A); chk("c3_rv0", p0_rvalid, 0);
      @(negedge clk);
      #1 chk("c4_p1", p1_ready, 1); chk("c4_rv0", p0_rvalid, 1); chk("c4_rv1", p1_rvalid, 0);
      @(negedge clk);
      p0_valid = 1'b0; p1_valid = 1'b0;
      #1 chk("c5_rv1", p1_rvalid, 1); chk("c5_rv0", p0_rvalid, 0);
      @(negedge clk);
      // mixed: p0 write vs p1 read, pointer at p0
      p0_valid = 1'b1; p0_we = 1'b1; p0_addr = 15'h0100; p0_wdata = 8'h3C;
      p1_valid = 1'b1; p1_we = 1'b0; p1_addr = 15'h0101;
      #1 chk("m_p0", p0_ready, 1); chk("m_p1", p1_ready, 0); chk("m_we", mem_we, 4'h3);
      chk("m_addr", mem_addr, 14'h80); chk("m_din", mem_din, 16'h3C3C);
      @(negedge clk);
      p0_valid = 1'b0;
      #1 chk("m_p1b", p1_ready, 1); chk("m_addr2", mem_addr, 14'h80); chk("m_we2", mem_we, 0);
      @(negedge clk);
      p1_valid = 1'b0;
      #1 chk("m_rv1", p1_rvalid, 1); chk("m_rd1", p1_rdata, 8'h00); chk("m_mem", mdl[16'h80], 16'h003C);
      @(negedge clk);
      // reset pulse after a read is accepted
      p0_valid = 1'b1; p0_we = 1'b0; p0_addr = 15'h0003;
      #1 chk("r_ready", p0_ready, 1);
      #1 rst_n = 1'b0;
      #1 chk("r_ready0", p0_ready, 0); chk("r_we0", mem_we, 0);
      chk("r_init0", init_done, 0); chk("r_addr0", mem_addr, 0);
      rst_n = 1'b1;
      #1 chk("r_clr_we", mem_we, 4'hF); chk("r_clr_addr", mem_addr, 0); chk("r_ready1", p0_ready, 0);
      @(negedge clk);
      #1 chk("r_rvalid", p0_rvalid, 0); chk("r_clr_addr1", mem_addr, 1); chk("r_init1", init_done, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
